// File: rtl/axis_fork_n.sv
// axis_fork_n: parametrised N-way AXI-Stream fork (eager fork).
// Each input beat goes to every branch (MODE=0) or to the branches that s_tmask
// selects (MODE=1). Each branch may accept independently. Per-branch done flags
// record which branches have already taken the beat. The input is released only
// when every selected branch has the beat.
// Ports:
//   clk, rstn                  clock and asynchronous active-low reset
//   s_tvalid/s_tready          input handshake
//   s_tdata/s_tlast/s_tmask    input payload, packet end and branch select
//   m_tvalid/m_tready          per-branch handshake (CH_NUM bits)
//   m_tdata/m_tlast            per-branch copies of s_tdata/s_tlast
//   drop_cnt                   saturating count of beats accepted with an empty mask
// s_tready depends combinationally on m_tready. m_tvalid never depends on m_tready.
module axis_fork_n #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned MODE    = 0,
  parameter int unsigned CNT_WD  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_WD-1:0]        s_tdata,
  input  logic                      s_tlast,
  input  logic [CH_NUM-1:0]         s_tmask,
  output logic [CH_NUM-1:0]         m_tvalid,
  input  logic [CH_NUM-1:0]         m_tready,
  output logic [CH_NUM*DATA_WD-1:0] m_tdata,
  output logic [CH_NUM-1:0]         m_tlast,
  output logic [CNT_WD-1:0]         drop_cnt
);

  logic                en_q;
  logic [CH_NUM-1:0]   done_q, done_d;
  logic [CH_NUM-1:0]   sel, ok;
  logic                acc;
  logic [CNT_WD-1:0]   drop_cnt_q, drop_cnt_d;

  always_comb begin
    sel      = (MODE == 0) ? {CH_NUM{1'b1}} : s_tmask;
    m_tvalid = {CH_NUM{en_q & s_tvalid}} & sel & ~done_q;
    // A branch does not block release if it is deselected, has already taken
    // the beat, or is taking it now.
    ok       = ~sel | done_q | m_tready;
    s_tready = en_q & (&ok);
    acc      = s_tvalid & s_tready;
    m_tdata  = {CH_NUM{s_tdata}};
    m_tlast  = {CH_NUM{s_tlast}};
    drop_cnt = drop_cnt_q;
  end

  // When the beat is accepted, all done bits clear. This takes priority over a
  // branch that completes in the same cycle.
  always_comb begin
    done_d = done_q;
    if (acc) begin
      done_d = '0;
    end else begin
      done_d = done_q | (m_tvalid & m_tready);
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (acc && (sel == '0) && (drop_cnt_q != {CNT_WD{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(CNT_WD-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q       <= 1'b0;
      done_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      en_q       <= 1'b1;
      done_q     <= done_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
